// File: rtl/gate_truth_table_checker_if.sv
// Signal bundle between the truth-table checker and its host/gate under test.
// Optional fail_mask exists only when GATE_CHK_FAIL_MASK_EN is defined.
interface gate_truth_table_checker_if #(
    parameter int N_IN  = 2,
    parameter int CNT_W = 8
);
    logic               start;
    logic               resp;
    logic [N_IN-1:0]    stim;
    logic               busy;
    logic               done;
    logic               pass;
    logic [CNT_W-1:0]   err_count;
    logic               first_fail_valid;
    logic [N_IN-1:0]    first_fail_vec;
`ifdef GATE_CHK_FAIL_MASK_EN
    logic [(1<<N_IN)-1:0] fail_mask;
`endif

    modport master (
        input  start, resp,
        output stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
`ifdef GATE_CHK_FAIL_MASK_EN
        , output fail_mask
`endif
    );

    modport slave (
        output start, resp,
        input  stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec
`ifdef GATE_CHK_FAIL_MASK_EN
        , input fail_mask
`endif
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Sweeps every input vector onto a gate, samples its output after a settle window
// and compares against TRUTH_TABLE. Define GATE_CHK_FAIL_MASK_EN to add fail_mask.
module gate_truth_table_checker #(
    parameter int                   N_IN        = 2,
    parameter logic [(1<<N_IN)-1:0] TRUTH_TABLE = 4'b0111,
    parameter int                   SETTLE      = 4,
    parameter int                   CNT_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    gate_truth_table_checker_if.master    bus
);
    localparam int NV = 1 << N_IN;
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

    state_t            state, state_n;
    logic [SW-1:0]     settle_cnt, settle_cnt_n;
    logic [N_IN-1:0]   stim_q, stim_n;
    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              pass_q, pass_n;
    logic [CNT_W-1:0]  err_q, err_n;
    logic              ffv_q, ffv_n;
    logic [N_IN-1:0]   ffvec_q, ffvec_n;
    logic [NV-1:0]     mask_q, mask_n;
    logic              mismatch;

    assign mismatch = bus.resp != TRUTH_TABLE[stim_q];

    // NOTE: every next-value gets a default before the case so no latches are inferred.
    always_comb begin
        state_n      = state;
        settle_cnt_n = settle_cnt;
        stim_n       = stim_q;
        busy_n       = busy_q;
        done_n       = 1'b0;
        pass_n       = pass_q;
        err_n        = err_q;
        ffv_n        = ffv_q;
        ffvec_n      = ffvec_q;
        mask_n       = mask_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n      = ST_SETTLE;
                    stim_n       = '0;
                    settle_cnt_n = '0;
                    busy_n       = 1'b1;
                    pass_n       = 1'b0;
                    err_n        = '0;
                    ffv_n        = 1'b0;
                    ffvec_n      = '0;
                    mask_n       = '0;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt != SW'(SETTLE - 1)) begin
                    settle_cnt_n = settle_cnt + 1'b1;
                end else begin
                    if (mismatch) begin
                        if (err_q != '1) err_n = err_q + 1'b1;
                        if (!ffv_q) begin
                            ffv_n   = 1'b1;
                            ffvec_n = stim_q;
                        end
                        mask_n[stim_q] = 1'b1;
                    end
                    settle_cnt_n = '0;
                    if (stim_q != '1) begin
                        stim_n = stim_q + 1'b1;
                    end else begin
                        // Final vector: pass reflects the count including this sample.
                        state_n = ST_IDLE;
                        stim_n  = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == '0);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
            mask_q     <= '0;
        end else begin
            state      <= state_n;
            settle_cnt <= settle_cnt_n;
            stim_q     <= stim_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            pass_q     <= pass_n;
            err_q      <= err_n;
            ffv_q      <= ffv_n;
            ffvec_q    <= ffvec_n;
            mask_q     <= mask_n;
        end
    end

    assign bus.stim             = stim_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
`ifdef GATE_CHK_FAIL_MASK_EN
    assign bus.fail_mask        = mask_q;
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Randomized bench: gate response tables checked against a cycle-position model,
// plus literal expectations for the default and 3-input configurations.
module tb_gate_truth_table_checker;
    localparam int         N_IN  = 2;
    localparam int         SETTLE = 4;
    localparam int         CNT_W = 8;
    localparam int         NV    = 4;
    localparam int         T     = NV * SETTLE;
    localparam logic [3:0] TT    = 4'b0111;
    localparam int         N2    = 3;
    localparam logic [7:0] TT2   = 8'b0111_1111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] resp_tbl  = TT;
    logic [7:0] resp_tbl2 = TT2;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    gate_truth_table_checker_if #(.N_IN(N_IN), .CNT_W(CNT_W)) bus ();
    gate_truth_table_checker_if #(.N_IN(N2),   .CNT_W(CNT_W)) bus2 ();

    assign bus.resp  = resp_tbl[bus.stim];
    assign bus2.resp = resp_tbl2[bus2.stim];

    gate_truth_table_checker #(.N_IN(N_IN), .TRUTH_TABLE(TT), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gate_truth_table_checker #(.N_IN(N2), .TRUTH_TABLE(TT2), .SETTLE(1), .CNT_W(CNT_W)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the sweep (edges since the start edge) and the
    // response table captured when the sweep began.
    logic       m_active, m_done_pulse, m_ran;
    int         m_d;
    logic [3:0] m_tbl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active     <= 1'b0;
            m_done_pulse <= 1'b0;
            m_ran        <= 1'b0;
            m_d          <= 0;
            m_tbl        <= '0;
        end else begin
            m_done_pulse <= 1'b0;
            if (m_active) begin
                m_d <= m_d + 1;
                if (m_d + 1 == T) begin
                    m_active     <= 1'b0;
                    m_done_pulse <= 1'b1;
                end
            end else if (bus.start) begin
                m_active <= 1'b1;
                m_d      <= 0;
                m_tbl    <= resp_tbl;
                m_ran    <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int         sampled;
        int         cnt;
        logic       ffv;
        int         ffvec;
        logic [3:0] mask;
        if (!rst) begin
            sampled = m_d / SETTLE;
            cnt = 0; ffv = 1'b0; ffvec = 0; mask = '0;
            for (int v = 0; v < sampled; v++) begin
                if (m_tbl[v] != TT[v]) begin
                    cnt++;
                    mask[v] = 1'b1;
                    if (!ffv) begin ffv = 1'b1; ffvec = v; end
                end
            end
            check("busy", bus.busy, m_active);
            check("done", bus.done, m_done_pulse);
            check("stim", bus.stim, m_active ? (m_d / SETTLE) : 0);
            check("err_count", bus.err_count, (cnt > 255) ? 255 : cnt);
            check("pass", bus.pass, (!m_active && m_ran && cnt == 0));
            check("first_fail_valid", bus.first_fail_valid, ffv);
            check("first_fail_vec", bus.first_fail_vec, ffvec);
`ifdef GATE_CHK_FAIL_MASK_EN
            check("fail_mask", bus.fail_mask, mask);
`endif
        end
    end

    task automatic sweep(input logic [3:0] tbl, input int poke, output int lat);
        resp_tbl = tbl;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            bus.start = (lat == poke);
        end while (!bus.done && lat < 100);
        bus.start = 1'b0;
    endtask

    task automatic sweep2(input logic [7:0] tbl, output int lat);
        resp_tbl2 = tbl;
        @(posedge clk); #1 bus2.start = 1'b1;
        @(posedge clk); #1 bus2.start = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus2.done && lat < 100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        bus.start  = 1'b0;
        bus2.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        check("reset busy", bus.busy, 0);
        check("reset err_count", bus.err_count, 0);
        check("reset pass", bus.pass, 0);

        // Correct NAND response
        sweep(TT, 0, lat);
        check("nand latency", lat, 16);
        check("nand pass", bus.pass, 1);
        check("nand err_count", bus.err_count, 0);
        check("nand ffv", bus.first_fail_valid, 0);

        // Response stuck at 1
        sweep(4'b1111, 0, lat);
        check("stuck1 err_count", bus.err_count, 1);
        check("stuck1 ffvec", bus.first_fail_vec, 3);
        check("stuck1 ffv", bus.first_fail_valid, 1);
        check("stuck1 pass", bus.pass, 0);
`ifdef GATE_CHK_FAIL_MASK_EN
        check("stuck1 mask", bus.fail_mask, 4'b1000);
`endif

        // AND instead of NAND: every vector wrong
        sweep(4'b1000, 0, lat);
        check("and err_count", bus.err_count, 4);
        check("and ffvec", bus.first_fail_vec, 0);
        check("and pass", bus.pass, 0);
`ifdef GATE_CHK_FAIL_MASK_EN
        check("and mask", bus.fail_mask, 4'b1111);
`endif

        // start re-pulsed mid-sweep is ignored
        sweep(TT, 5, lat);
        check("poke latency", lat, 16);

        // start held high: back-to-back sweeps
        resp_tbl = 4'b1000;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bus.done && lat < 100);
        check("b2b first latency", lat, 16);
        check("b2b first err_count", bus.err_count, 4);
        resp_tbl = TT;
        @(posedge clk); #1;
        check("b2b restart busy", bus.busy, 1);
        check("b2b cleared err_count", bus.err_count, 0);
        bus.start = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!bus.done && lat < 100);
        check("b2b second latency", lat, 16);
        check("b2b second pass", bus.pass, 1);

        // Asynchronous reset mid failing sweep
        resp_tbl = 4'b1000;
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre-reset err_count", bus.err_count, 1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", bus.busy, 0);
        check("async rst err_count", bus.err_count, 0);
        check("async rst ffv", bus.first_fail_valid, 0);
        check("async rst stim", bus.stim, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        sweep(TT, 0, lat);
        check("post-reset latency", lat, 16);
        check("post-reset pass", bus.pass, 1);

        // Randomized response tables, occasional ignored start pulses
        repeat (24) begin
            sweep(4'($urandom), int'($urandom_range(0, 14)), lat);
            check("random latency", lat, 16);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // 3-input NAND, SETTLE=1
        sweep2(TT2, lat);
        check("nand3 latency", lat, 8);
        check("nand3 pass", bus2.pass, 1);
        check("nand3 err_count", bus2.err_count, 0);
        sweep2(TT2 ^ 8'b0010_0000, lat);
        check("nand3 bad latency", lat, 8);
        check("nand3 bad err_count", bus2.err_count, 1);
        check("nand3 bad ffvec", bus2.first_fail_vec, 5);
        check("nand3 bad pass", bus2.pass, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
- Hardware self-checking harness for the small combinational gates in this codebase (nand, nor, xor, ...).
- Drives every input combination onto a gate under test and holds each one for a settle window.
- Samples the gate's single output and compares it against a parameterised expected truth table.
- Accumulates a mismatch count and records the first failing vector; reports pass/fail with a done pulse. Sits beside the gate as the on-chip reader of its response.

Parameters:
N_IN, 2, number of gate inputs; legal 1..4
TRUTH_TABLE, 4'b0111, width 2**N_IN; bit k = expected output for stimulus vector k; default = NAND
SETTLE, 4, cycles each vector is held before sampling; legal >= 1
CNT_W, 8, width of the mismatch counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
resp  input  1  output of the gate under test
stim  output  N_IN  stimulus to the gate; stim[N_IN-1] is the MSB (input "a" for N_IN=2)
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  high after a sweep with zero mismatches; held until next start
err_count  output  CNT_W  mismatches in the last or current sweep; saturates at all-ones
first_fail_valid  output  1  at least one mismatch recorded this sweep
first_fail_vec  output  N_IN  stimulus vector of the first mismatch

Behaviour:
- Reset (asynchronous, active-high): state=IDLE.
  - All outputs 0: stim, busy, done, pass, err_count, first_fail_valid, first_fail_vec. Settle counter 0.
- States: IDLE, SETTLE.
- IDLE, start=1 at an edge:
  - stim<=0, settle_cnt<=0, busy<=1, state<=SETTLE.
  - err_count, pass, first_fail_valid, first_fail_vec all cleared to 0.
- SETTLE, settle_cnt != SETTLE-1: settle_cnt increments.
- SETTLE, settle_cnt == SETTLE-1: resp is sampled and compared with TRUTH_TABLE[stim].
  - Mismatch: err_count increments (saturating).
  - Mismatch and first_fail_valid=0: first_fail_vec<=stim, first_fail_valid<=1.
  - stim != all-ones: stim<=stim+1, settle_cnt<=0.
  - stim == all-ones (last vector): state<=IDLE, stim<=0, busy<=0, done<=1.
  - On that final edge, pass<=1 iff the final error count, including this sample, is zero.
- Timing: each vector is held exactly SETTLE cycles. done rises 2**N_IN*SETTLE edges after the start edge (16 for defaults).
- done is high for exactly one cycle; otherwise 0.
- start while busy is ignored. start held high continuously produces back-to-back sweeps, because IDLE accepts it on the cycle done is high.
- Reset mid-sweep aborts immediately to reset values. No done pulse; partial results are discarded.
- resp is treated as a registered-domain signal. The gate's combinational delay must fit within SETTLE cycles.

Optional Feature:
- Macro GATE_CHK_FAIL_MASK_EN.
- Defined: adds output fail_mask, width 2**N_IN.
  - Bit k is set on a mismatch for vector k.
  - Cleared on start and on reset; held after done.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, resp = ~(stim[1]&stim[0]), pulse start -> busy for 16 cycles; stim sequence 00,01,10,11 each held 4 cycles; done pulse; pass=1, err_count=0, first_fail_valid=0.
- resp stuck at 1 -> err_count=1, first_fail_vec=2'b11, first_fail_valid=1, pass=0, fail_mask=4'b1000 (with macro).
- resp = stim[1]&stim[0] (AND, inverted from expected) -> err_count=4, first_fail_vec=2'b00, pass=0, fail_mask=4'b1111.
- start pulsed again at cycle 5 of a sweep -> ignored, done still at edge 16. start held high -> second sweep begins on the done cycle; results cleared at that edge.
- rst asserted asynchronously at cycle 6 of a failing sweep -> all outputs 0 immediately, no done. Fresh start then gives a normal 16-cycle sweep.
- N_IN=3, TRUTH_TABLE=8'b0111_1111 (3-input NAND), SETTLE=1, correct resp -> done at edge 8, pass=1; force resp wrong on vector 5 -> err_count=1, first_fail_vec=3'b101.
